bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter and transaction sequencer for the shared CPU peripheral bus. It sits in front of the address decoder: master 0 is the CPU data port, master 1 is a secondary requester (DMA/VGA fetch). It grants one transaction at a time with round-robin fairness, drives the bus for a per-region number of wait states, and returns read data and a one-cycle acknowledge to the winning master.

## Interface
- IO_WAIT, 3: extra ACCESS cycles for addresses with addr[31:16] != 0 (peripheral region); 0..15
- MEM_WAIT, 0: extra ACCESS cycles for addresses with addr[31:16] == 0 (memory region); 0..15
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  master 0 request; held high until ack
- m0_addr  in  32  master 0 address
- m0_wdata  in  32  master 0 write data
- m0_rw  in  1  master 0 direction, 1 = write, 0 = read
- m0_ack  out  1  master 0 transaction complete, one-cycle pulse
- m0_rdata  out  32  master 0 read data, valid with m0_ack on reads, then held
- m1_req, m1_addr, m1_wdata, m1_rw, m1_ack, m1_rdata: same as master 0, for master 1
- bus_addr  out  32  address to decoder/slaves
- bus_wdata  out  32  write data to slaves
- bus_rw  out  1  direction to slaves (1 = write)
- bus_stb  out  1  transaction strobe, high only in ACCESS
- bus_rdata  in  32  read data from selected slave
- owner  out  1  master currently granted (0/1); meaningful while busy
- busy  out  1  high in ACCESS and DONE

## Operation
- States: IDLE, ACCESS, DONE. Reset: state IDLE, all outputs 0, wait counter 0, last-served = 1 (master 0 wins the first contention).
- IDLE: no request -> stay. Exactly one req -> grant it. Both -> grant the master not equal to last-served. On grant: latch its addr/wdata/rw into bus_addr/bus_wdata/bus_rw, set owner, last-served := winner, load counter with IO_WAIT or MEM_WAIT from the latched addr[31:16], go to ACCESS.
- ACCESS: bus_stb = 1; bus_addr/wdata/rw stable. Counter != 0 -> decrement, stay. Counter == 0 -> on a read, capture bus_rdata into owner's rdata register; go to DONE.
- DONE: owner's ack = 1 for exactly this cycle; bus_stb = 0; go to IDLE. No new grant in DONE.
- Master rule: deassert req on the edge where ack = 1 is sampled, so req is low in the following IDLE cycle.
- Req dropped during ACCESS (protocol violation): the transaction still completes and ack still pulses.
- Non-owner's ack is 0 and its rdata is unchanged. Writes never change any rdata register.
- bus_addr/wdata/rw hold their last value in IDLE and DONE; owner holds its last value.
- Reset asserted mid-transaction: state immediately IDLE, bus_stb/ack/busy immediately 0, no ack issued, last-served = 1.
- Counter is 4 bits; parameter values above 15 are illegal.

## Timing
- Grant decision in the IDLE cycle that sees req; bus_stb rises on the next edge.
- ACCESS lasts W+1 cycles (W = selected wait parameter); bus_rdata sampled on the last ACCESS edge.
- Req high in cycle 0 -> ack in cycle W+2. Memory (W = 0): ack in cycle 2. Peripheral (W = 3): ack in cycle 5.
- Back-to-back from one master: req reasserted in the IDLE cycle after DONE -> new ACCESS next edge; one transaction per W+3 cycles.
- Contention fairness: with both reqs held continuously, grants alternate 0,1,0,1.

## Test plan
- Reset then m0 read of 0x0000_0010 (MEM_WAIT=0), bus_rdata=0xDEADBEEF -> bus_stb high cycles 1, m0_ack cycle 2, m0_rdata=0xDEADBEEF, m1_ack never.
- m1 write 0x000F_FF00 data 0x0000_00FF (IO_WAIT=3) -> bus_stb cycles 1-4 with bus_rw=1, addr/wdata stable, m1_ack cycle 5, m0_rdata/m1_rdata unchanged.
- Both masters request in same cycle after reset and keep re-requesting -> grant order 0,1,0,1, owner matches, no ack overlap.
- m0 reads 0x0000_0004 repeatedly, bus_rdata incrementing 1,2,3 -> acks every 3 cycles, m0_rdata = 1,2,3.
- rst pulsed in the second ACCESS cycle of an IO read -> bus_stb/busy drop immediately, no ack; next simultaneous request grants m0.
- m0 drops req mid-ACCESS -> transaction completes, m0_ack still pulses once, arbiter returns to IDLE.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Shared bus bundle between two requesting masters, the arbiter and the slave side.
// The slave modport is the arbiter's view; the master modport is the requesters' view.
interface bus_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_rw;
  logic        m0_ack;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_rw;
  logic        m1_ack;
  logic [31:0] m1_rdata;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rw;
  logic        bus_stb;
  logic [31:0] bus_rdata;
  logic        owner;
  logic        busy;

  modport slave (
    input  m0_req, m0_addr, m0_wdata, m0_rw,
    input  m1_req, m1_addr, m1_wdata, m1_rw,
    input  bus_rdata,
    output m0_ack, m0_rdata, m1_ack, m1_rdata,
    output bus_addr, bus_wdata, bus_rw, bus_stb, owner, busy
  );

  modport master (
    output m0_req, m0_addr, m0_wdata, m0_rw,
    output m1_req, m1_addr, m1_wdata, m1_rw,
    output bus_rdata,
    input  m0_ack, m0_rdata, m1_ack, m1_rdata,
    input  bus_addr, bus_wdata, bus_rw, bus_stb, owner, busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter driving one bus transaction at a time.
// Latency: req seen in IDLE -> ack W+2 cycles later (W = region wait states).
// Backpressure: masters hold req until ack; one transaction in flight, no grant in DONE.
module bus_arbiter #(
  parameter int IO_WAIT  = 3,
  parameter int MEM_WAIT = 0
) (
  input logic          clk,
  input logic          rst,
  bus_arbiter_if.slave bif
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] IO_W  = 4'(IO_WAIT);
  localparam logic [3:0] MEM_W = 4'(MEM_WAIT);

  state_t      state;
  logic [3:0]  cnt;
  logic        last;
  logic        any_req;
  logic        pick_m1;
  logic [31:0] win_addr;

  // Master 1 wins when it is the only requester, or on contention when master 0 went last.
  always_comb begin
    any_req  = bif.m0_req | bif.m1_req;
    pick_m1  = bif.m1_req & (~bif.m0_req | ~last);
    win_addr = pick_m1 ? bif.m1_addr : bif.m0_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 4'd0;
      last          <= 1'b1;
      bif.owner     <= 1'b0;
      bif.busy      <= 1'b0;
      bif.bus_stb   <= 1'b0;
      bif.bus_addr  <= 32'd0;
      bif.bus_wdata <= 32'd0;
      bif.bus_rw    <= 1'b0;
      bif.m0_ack    <= 1'b0;
      bif.m1_ack    <= 1'b0;
      bif.m0_rdata  <= 32'd0;
      bif.m1_rdata  <= 32'd0;
    end else begin
      bif.m0_ack <= 1'b0;
      bif.m1_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            bif.bus_addr  <= win_addr;
            bif.bus_wdata <= pick_m1 ? bif.m1_wdata : bif.m0_wdata;
            bif.bus_rw    <= pick_m1 ? bif.m1_rw : bif.m0_rw;
            bif.owner     <= pick_m1;
            last          <= pick_m1;
            cnt           <= (win_addr[31:16] != 16'h0000) ? IO_W : MEM_W;
            bif.bus_stb   <= 1'b1;
            bif.busy      <= 1'b1;
            state         <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!bif.bus_rw) begin
              if (bif.owner) bif.m1_rdata <= bif.bus_rdata;
              else           bif.m0_rdata <= bif.bus_rdata;
            end
            if (bif.owner) bif.m1_ack <= 1'b1;
            else           bif.m0_ack <= 1'b1;
            bif.bus_stb <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          bif.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: expected acks are queued at request time and
// popped by a negedge monitor that checks master, cycle, owner and read data.
module tb_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;

  bus_arbiter_if bif();

  bus_arbiter #(.IO_WAIT(3), .MEM_WAIT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          m;
    int          cyc;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] rd0_m = 32'd0;
  logic [31:0] rd1_m = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every ack must match the head of the expectation queue.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && (bif.m0_ack || bif.m1_ack)) begin
      check("ack_overlap", 32'(bif.m0_ack & bif.m1_ack), 32'd0);
      check("ack_expected", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("ack_master", 32'(bif.m1_ack), 32'(e.m));
        check("ack_cycle", 32'(cyc), 32'(e.cyc));
        check("ack_owner", 32'(bif.owner), 32'(e.m));
        check("m0_rdata", bif.m0_rdata, e.rd0);
        check("m1_rdata", bif.m1_rdata, e.rd1);
      end
    end
  end

  // Single-master transaction, entered just after a rising edge; returns just after
  // the edge that ends DONE with req low. drop >= 0 drops req that many cycles in.
  task automatic txn(input bit m, input logic [31:0] addr, input logic [31:0] wd,
                     input bit rw, input logic [31:0] rd, input int drop);
    int   w;
    int   s;
    bit   done;
    exp_t e;
    w = (addr[31:16] != 16'h0) ? 3 : 0;
    s = cyc;
    bif.bus_rdata = rd;
    if (m) begin
      bif.m1_req = 1'b1; bif.m1_addr = addr; bif.m1_wdata = wd; bif.m1_rw = rw;
      if (!rw) rd1_m = rd;
    end else begin
      bif.m0_req = 1'b1; bif.m0_addr = addr; bif.m0_wdata = wd; bif.m0_rw = rw;
      if (!rw) rd0_m = rd;
    end
    e.m = m; e.cyc = s + w + 2; e.rd0 = rd0_m; e.rd1 = rd1_m;
    sbq.push_back(e);
    done = 1'b0;
    for (int k = 0; k < w + 10 && !done; k++) begin
      @(negedge clk);
      if (k == drop) begin
        if (m) bif.m1_req = 1'b0; else bif.m0_req = 1'b0;
      end
      check("bus_stb", 32'(bif.bus_stb), 32'(cyc >= s + 1 && cyc <= s + w + 1));
      check("busy", 32'(bif.busy), 32'(cyc >= s + 1 && cyc <= s + w + 2));
      if (bif.bus_stb) begin
        check("bus_addr", bif.bus_addr, addr);
        check("bus_wdata", bif.bus_wdata, wd);
        check("bus_rw", 32'(bif.bus_rw), 32'(rw));
      end
      if (m ? bif.m1_ack : bif.m0_ack) done = 1'b1;
    end
    check("ack_timeout", 32'(done), 32'd1);
    @(posedge clk); #1;
    bif.m0_req = 1'b0;
    bif.m1_req = 1'b0;
  endtask

  // Both masters read continuously for n grants; expected order 0,1,0,1...
  task automatic contend(input int n, input logic [31:0] rd);
    int   s;
    int   got;
    exp_t e;
    s = cyc;
    bif.bus_rdata = rd;
    bif.m0_req = 1'b1; bif.m0_addr = 32'h0000_0100; bif.m0_wdata = 32'd0; bif.m0_rw = 1'b0;
    bif.m1_req = 1'b1; bif.m1_addr = 32'h0000_0200; bif.m1_wdata = 32'd0; bif.m1_rw = 1'b0;
    for (int i = 0; i < n; i++) begin
      e.m = 1'(i % 2);
      if (e.m) rd1_m = rd; else rd0_m = rd;
      e.cyc = s + 2 + 3 * i; e.rd0 = rd0_m; e.rd1 = rd1_m;
      sbq.push_back(e);
    end
    got = 0;
    for (int k = 0; k < 3 * n + 10 && got < n; k++) begin
      @(negedge clk);
      if (bif.busy) check("owner_busy", 32'(bif.owner), 32'(((cyc - s - 1) / 3) % 2));
      if (bif.m0_ack || bif.m1_ack) got++;
    end
    check("contend_acks", 32'(got), 32'(n));
    @(posedge clk); #1;
    bif.m0_req = 1'b0;
    bif.m1_req = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rd0_m = 32'd0;
    rd1_m = 32'd0;
  endtask

  initial begin
    bif.m0_req = 1'b0; bif.m0_addr = 32'd0; bif.m0_wdata = 32'd0; bif.m0_rw = 1'b0;
    bif.m1_req = 1'b0; bif.m1_addr = 32'd0; bif.m1_wdata = 32'd0; bif.m1_rw = 1'b0;
    bif.bus_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_stb", 32'(bif.bus_stb), 32'd0);
    check("rst_busy", 32'(bif.busy), 32'd0);
    check("rst_owner", 32'(bif.owner), 32'd0);
    check("rst_ack", 32'({bif.m0_ack, bif.m1_ack}), 32'd0);
    check("rst_rdata0", bif.m0_rdata, 32'd0);
    check("rst_rdata1", bif.m1_rdata, 32'd0);
    check("rst_addr", bif.bus_addr, 32'd0);
    @(posedge clk); #1;

    // memory read, peripheral write
    txn(1'b0, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, -1);
    txn(1'b1, 32'h000F_FF00, 32'h0000_00FF, 1'b1, 32'h1234_5678, -1);
    check("hold_addr", bif.bus_addr, 32'h000F_FF00);

    // back-to-back memory reads from master 0
    txn(1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'd1, -1);
    txn(1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'd2, -1);
    txn(1'b0, 32'h0000_0004, 32'h0, 1'b0, 32'd3, -1);

    // req dropped in the second ACCESS cycle of a peripheral read
    txn(1'b0, 32'h0002_0000, 32'h0, 1'b0, 32'hCAFE_0001, 2);
    @(negedge clk);
    check("idle_after_drop", 32'(bif.busy), 32'd0);
    @(posedge clk); #1;

    do_reset();
    contend(4, 32'hA5A5_0001);

    // reset in the second ACCESS cycle of a peripheral read
    bif.m0_req = 1'b1; bif.m0_addr = 32'h0001_0000; bif.m0_rw = 1'b0;
    bif.bus_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_stb", 32'(bif.bus_stb), 32'd1);
    rst = 1'b1;
    bif.m0_req = 1'b0;
    #1;
    check("mid_rst_stb", 32'(bif.bus_stb), 32'd0);
    check("mid_rst_busy", 32'(bif.busy), 32'd0);
    check("mid_rst_ack", 32'({bif.m0_ack, bif.m1_ack}), 32'd0);
    check("mid_rst_rdata0", bif.m0_rdata, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd0_m = 32'd0;
    rd1_m = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    contend(2, 32'h0000_7777);

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
